// File: rtl/store_drain_unit_pkg.sv
// Shared core definitions for the store drain path: size encodings, the queued
// entry layout and the lane formatter used by both the store and load units.
package store_drain_unit_pkg;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_TRI  = 2'd3;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
  } sdu_entry_t;

  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  byte_en;
  } lane_t;

  // Sub-word stores place byte k on lane offset+k; bytes that would spill past
  // lane 3 are dropped rather than wrapped into the next word.
  function automatic lane_t lane_format(input logic [1:0]  size,
                                        input logic [1:0]  offset,
                                        input logic [31:0] data);
    lane_t       r;
    int unsigned lane;
    r    = '0;
    lane = 0;
    if (size == SZ_WORD) begin
      r.wdata   = data;
      r.byte_en = '1;
    end else begin
      for (int unsigned k = 0; k < 3; k++) begin
        lane = k + 32'(offset);
        if (k < 32'(size) && lane < 4) begin
          r.wdata[8*lane +: 8] = data[8*k +: 8];
          r.byte_en[lane]      = 1'b1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/store_drain_unit_if.sv
// Commit-port, cache-drain and forwarding-lookup signals of the store drain unit.
interface store_drain_unit_if;

  logic        MemWrite_2DM;
  logic [31:0] data_address_2DM;
  logic [31:0] data_write_2DM;
  logic [1:0]  data_write_size_2DM;
  logic        sdu_full;
  logic        sdu_empty;
  logic        sdu_overflow;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic [31:0] fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_byte_en;

  modport slave (
    input  MemWrite_2DM, data_address_2DM, data_write_2DM, data_write_size_2DM,
    input  mem_req_ready, fwd_addr,
    output sdu_full, sdu_empty, sdu_overflow,
    output mem_req_valid, mem_addr, mem_wdata, mem_byte_en,
    output fwd_hit, fwd_data, fwd_byte_en
  );

  modport master (
    output MemWrite_2DM, data_address_2DM, data_write_2DM, data_write_size_2DM,
    output mem_req_ready, fwd_addr,
    input  sdu_full, sdu_empty, sdu_overflow,
    input  mem_req_valid, mem_addr, mem_wdata, mem_byte_en,
    input  fwd_hit, fwd_data, fwd_byte_en
  );

endinterface

// File: rtl/store_drain_unit_fwd_match.sv
// Youngest-match word-address search over the store queue for load forwarding.
module sdu_fwd_match
  import store_drain_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  sdu_entry_t                 entries_i [DEPTH],
  input  logic [DEPTH-1:0]           valid_i,
  input  logic [$clog2(DEPTH)-1:0]   wr_ptr_i,
  input  logic [29:0]                addr_i,
  output logic                       hit_o,
  output logic [31:0]                data_o,
  output logic [3:0]                 byte_en_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match written is the youngest entry.
  always_comb begin
    hit_o     = 1'b0;
    data_o    = '0;
    byte_en_o = '0;
    idx       = '0;
    for (int unsigned d = DEPTH; d > 0; d--) begin
      idx = wr_ptr_i - PTR_W'(d);
      if (valid_i[idx] && entries_i[idx].addr == addr_i) begin
        hit_o     = 1'b1;
        data_o    = entries_i[idx].wdata;
        byte_en_o = entries_i[idx].byte_en;
      end
    end
  end

endmodule

// File: rtl/store_drain_unit.sv
// In-order store FIFO between ROB store commit and the data cache, with
// byte-lane formatting at enqueue and a store-to-load forwarding lookup.
module store_drain_unit
  import store_drain_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input logic               CLK,
  input logic               RESET,
  store_drain_unit_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  sdu_entry_t       entries_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             full, empty, enq, deq;
  lane_t            fmt;
  sdu_entry_t       new_entry;
  sdu_entry_t       head;
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] offs;
  logic             fwd_lo_unused;

  assign full  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign enq   = bus.MemWrite_2DM && !full;
  assign deq   = !empty && bus.mem_req_ready;

  always_comb begin
    fmt               = lane_format(bus.data_write_size_2DM, bus.data_address_2DM[1:0],
                                    bus.data_write_2DM);
    new_entry.addr    = bus.data_address_2DM[31:2];
    new_entry.wdata   = fmt.wdata;
    new_entry.byte_en = fmt.byte_en;
  end

  // A strobe while full is discarded even if a dequeue frees a slot this cycle.
  always_comb begin
    wr_d  = wr_q + PTR_W'(enq);
    rd_d  = rd_q + PTR_W'(deq);
    cnt_d = cnt_q + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
    ovf_d = ovf_q | (bus.MemWrite_2DM & full);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (enq) begin
      entries_q[wr_q] <= new_entry;
    end
  end

  // Slot i is live when its distance from the read pointer is below the count.
  always_comb begin
    valid = '0;
    offs  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs     = PTR_W'(i) - rd_q;
      valid[i] = ({1'b0, offs} < cnt_q);
    end
  end

  assign head = entries_q[rd_q];

  assign bus.sdu_full      = full;
  assign bus.sdu_empty     = empty;
  assign bus.sdu_overflow  = ovf_q;
  assign bus.mem_req_valid = !empty;
  assign bus.mem_addr      = empty ? '0 : {head.addr, 2'b00};
  assign bus.mem_wdata     = empty ? '0 : head.wdata;
  assign bus.mem_byte_en   = empty ? '0 : head.byte_en;

  assign fwd_lo_unused = ^bus.fwd_addr[1:0];

  sdu_fwd_match #(.DEPTH(DEPTH)) u_fwd_match (
    .entries_i (entries_q),
    .valid_i   (valid),
    .wr_ptr_i  (wr_q),
    .addr_i    (bus.fwd_addr[31:2]),
    .hit_o     (bus.fwd_hit),
    .data_o    (bus.fwd_data),
    .byte_en_o (bus.fwd_byte_en)
  );

endmodule

// File: tb/tb_store_drain_unit.sv
// Self-checking bench for store_drain_unit against a queue-based reference model.
module tb_store_drain_unit;

  localparam int DEPTH = 8;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  store_drain_unit_if bus();

  store_drain_unit #(.DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct {
    logic [29:0] a;
    logic [31:0] w;
    logic [3:0]  be;
  } ent_t;

  ent_t mq[$];
  bit   m_ovf;
  int   checks = 0;
  int   errors = 0;

  // Mask off n bytes of data, shift them up by the offset, keep the low word.
  function automatic ent_t model_fmt(logic [31:0] addr, logic [31:0] data, logic [1:0] sz);
    int          n, o;
    logic [63:0] wide;
    logic [7:0]  b;
    ent_t        e;
    n    = (sz == 2'd0) ? 4 : int'(sz);
    o    = (sz == 2'd0) ? 0 : int'(addr[1:0]);
    wide = ({32'b0, data} & ((64'd1 << (8*n)) - 64'd1)) << (8*o);
    b    = ((8'd1 << n) - 8'd1) << o;
    e.a  = addr[31:2];
    e.w  = wide[31:0];
    e.be = b[3:0];
    return e;
  endfunction

  function automatic ent_t fwd_lookup(logic [31:0] fa, output bit hit);
    ent_t e;
    e.a = '0; e.w = '0; e.be = '0;
    hit = 1'b0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].a == fa[31:2]) begin
        e   = mq[i];
        hit = 1'b1;
        break;
      end
    end
    return e;
  endfunction

  task automatic tick();
    bit   wr, full, deq;
    ent_t e;
    wr   = bus.MemWrite_2DM;
    full = (mq.size() == DEPTH);
    deq  = (mq.size() != 0) && bus.mem_req_ready;
    e    = model_fmt(bus.data_address_2DM, bus.data_write_2DM, bus.data_write_size_2DM);
    @(posedge CLK);
    if (wr && full) m_ovf = 1'b1;
    if (wr && !full) mq.push_back(e);
    if (deq) void'(mq.pop_front());
    #1;
  endtask

  task automatic set_idle();
    bus.MemWrite_2DM        = 1'b0;
    bus.data_address_2DM    = '0;
    bus.data_write_2DM      = '0;
    bus.data_write_size_2DM = '0;
    bus.mem_req_ready       = 1'b0;
    bus.fwd_addr            = '0;
  endtask

  task automatic drive_store(logic [31:0] a, logic [31:0] d, logic [1:0] sz);
    bus.MemWrite_2DM        = 1'b1;
    bus.data_address_2DM    = a;
    bus.data_write_2DM      = d;
    bus.data_write_size_2DM = sz;
  endtask

  task automatic test_reset();
    set_idle();
    #12;
    checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.mem_req_valid); end
    checks++; if (bus.sdu_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.sdu_empty); end
    checks++; if (bus.sdu_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus.sdu_full); end
    checks++; if (bus.sdu_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bus.sdu_overflow); end
    checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_byte_en} !== '0) begin errors++; $display("FAIL reset_head got %h %h %h exp 0", bus.mem_addr, bus.mem_wdata, bus.mem_byte_en); end
    checks++; if ({bus.fwd_hit, bus.fwd_data, bus.fwd_byte_en} !== '0) begin errors++; $display("FAIL reset_fwd got %b %h %h exp 0", bus.fwd_hit, bus.fwd_data, bus.fwd_byte_en); end
    RESET = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_byte_store();
    drive_store(32'h0000_1003, 32'h0000_00AB, 2'd1);
    #1;
    checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL byte_bypass got %b exp 0", bus.mem_req_valid); end
    tick();
    bus.MemWrite_2DM = 1'b0;
    checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL byte_valid got %b exp 1", bus.mem_req_valid); end
    checks++; if (bus.mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL byte_addr got %h exp 00001000", bus.mem_addr); end
    checks++; if (bus.mem_byte_en !== 4'b1000) begin errors++; $display("FAIL byte_en got %b exp 1000", bus.mem_byte_en); end
    checks++; if (bus.mem_wdata !== 32'hAB00_0000) begin errors++; $display("FAIL byte_wdata got %h exp ab000000", bus.mem_wdata); end
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    checks++; if (bus.sdu_empty !== 1'b1) begin errors++; $display("FAIL byte_drained got %b exp 1", bus.sdu_empty); end
  endtask

  task automatic test_tri_overflow_lanes();
    drive_store(32'h0000_2002, 32'h00CC_BBAA, 2'd3);
    tick();
    bus.MemWrite_2DM = 1'b0;
    checks++; if (bus.mem_addr !== 32'h0000_2000) begin errors++; $display("FAIL tri_addr got %h exp 00002000", bus.mem_addr); end
    checks++; if (bus.mem_byte_en !== 4'b1100) begin errors++; $display("FAIL tri_en got %b exp 1100", bus.mem_byte_en); end
    checks++; if (bus.mem_wdata !== 32'hBBAA_0000) begin errors++; $display("FAIL tri_wdata got %h exp bbaa0000", bus.mem_wdata); end
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
  endtask

  task automatic test_forward();
    drive_store(32'h0000_3000, 32'h1111_1111, 2'd0);
    tick();
    drive_store(32'h0000_3000, 32'h2222_2222, 2'd0);
    tick();
    bus.MemWrite_2DM = 1'b0;
    bus.fwd_addr = 32'h0000_3002;
    #1;
    checks++; if (bus.fwd_hit !== 1'b1) begin errors++; $display("FAIL fwd_hit got %b exp 1", bus.fwd_hit); end
    checks++; if (bus.fwd_data !== 32'h2222_2222) begin errors++; $display("FAIL fwd_youngest got %h exp 22222222", bus.fwd_data); end
    checks++; if (bus.fwd_byte_en !== 4'b1111) begin errors++; $display("FAIL fwd_en got %b exp 1111", bus.fwd_byte_en); end
    bus.fwd_addr = 32'h0000_3004;
    #1;
    checks++; if ({bus.fwd_hit, bus.fwd_data, bus.fwd_byte_en} !== '0) begin errors++; $display("FAIL fwd_miss got %b %h %b exp 0", bus.fwd_hit, bus.fwd_data, bus.fwd_byte_en); end
    bus.mem_req_ready = 1'b1;
    tick();
    tick();
    bus.mem_req_ready = 1'b0;
    checks++; if (bus.sdu_empty !== 1'b1) begin errors++; $display("FAIL fwd_drained got %b exp 1", bus.sdu_empty); end
  endtask

  task automatic test_full_overflow();
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      drive_store($urandom, $urandom, 2'($urandom_range(0, 3)));
      tick();
    end
    bus.MemWrite_2DM = 1'b0;
    checks++; if (bus.sdu_full !== 1'b1) begin errors++; $display("FAIL full_set got %b exp 1", bus.sdu_full); end
    checks++; if (bus.sdu_overflow !== 1'b0) begin errors++; $display("FAIL full_no_ovf got %b exp 0", bus.sdu_overflow); end
    drive_store(32'hDEAD_BEEF, 32'h5555_5555, 2'd0);
    tick();
    bus.MemWrite_2DM = 1'b0;
    checks++; if (bus.sdu_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", bus.sdu_overflow); end
    checks++; if (bus.sdu_full !== 1'b1) begin errors++; $display("FAIL ovf_still_full got %b exp 1", bus.sdu_full); end
    bus.mem_req_ready = 1'b1;
    n = 0;
    while (bus.mem_req_valid === 1'b1 && n < 20) begin
      if (mq.size() == 0) begin
        checks++; errors++; $display("FAIL drain_extra got entry %h exp none", bus.mem_addr);
      end else begin
        checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_byte_en} !== {mq[0].a, 2'b00, mq[0].w, mq[0].be})
          begin errors++; $display("FAIL drain_order got %h %h %b exp %h %h %b", bus.mem_addr, bus.mem_wdata, bus.mem_byte_en, {mq[0].a, 2'b00}, mq[0].w, mq[0].be); end
      end
      tick();
      n++;
    end
    bus.mem_req_ready = 1'b0;
    checks++; if (n !== DEPTH) begin errors++; $display("FAIL drain_count got %0d exp %0d", n, DEPTH); end
    checks++; if (bus.sdu_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", bus.sdu_overflow); end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int i = 0; i < 3; i++) begin
      drive_store($urandom, $urandom, 2'($urandom_range(0, 3)));
      tick();
    end
    bus.mem_req_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_store($urandom, $urandom, 2'($urandom_range(0, 3)));
      checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_byte_en} !== {mq[0].a, 2'b00, mq[0].w, mq[0].be})
        begin errors++; $display("FAIL b2b_head got %h %h %b exp %h %h %b", bus.mem_addr, bus.mem_wdata, bus.mem_byte_en, {mq[0].a, 2'b00}, mq[0].w, mq[0].be); end
      tick();
    end
    bus.MemWrite_2DM = 1'b0;
    n = 0;
    while (bus.mem_req_valid === 1'b1 && n < 10) begin
      tick();
      n++;
    end
    bus.mem_req_ready = 1'b0;
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", n); end
  endtask

  task automatic test_random();
    ent_t e;
    bit   hit;
    int   rdy_pct;
    for (int cyc = 0; cyc < 300; cyc++) begin
      rdy_pct = (cyc < 150) ? 25 : 75;
      bus.MemWrite_2DM        = ($urandom_range(0, 2) != 0);
      bus.data_address_2DM    = 32'h0000_4000 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
      bus.data_write_2DM      = $urandom;
      bus.data_write_size_2DM = 2'($urandom_range(0, 3));
      bus.mem_req_ready       = ($urandom_range(0, 99) < rdy_pct);
      bus.fwd_addr            = 32'h0000_4000 + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(0, 3));
      #1;
      e = fwd_lookup(bus.fwd_addr, hit);
      checks++; if ({bus.fwd_hit, bus.fwd_data, bus.fwd_byte_en} !== {hit, e.w, e.be})
        begin errors++; $display("FAIL rnd_fwd cyc %0d got %b %h %b exp %b %h %b", cyc, bus.fwd_hit, bus.fwd_data, bus.fwd_byte_en, hit, e.w, e.be); end
      checks++; if ({bus.mem_req_valid, bus.sdu_empty, bus.sdu_full, bus.sdu_overflow} !== {mq.size() != 0, mq.size() == 0, mq.size() == DEPTH, m_ovf})
        begin errors++; $display("FAIL rnd_flags cyc %0d got %b%b%b%b exp %b%b%b%b", cyc, bus.mem_req_valid, bus.sdu_empty, bus.sdu_full, bus.sdu_overflow, mq.size() != 0, mq.size() == 0, mq.size() == DEPTH, m_ovf); end
      if (mq.size() != 0) begin
        checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_byte_en} !== {mq[0].a, 2'b00, mq[0].w, mq[0].be})
          begin errors++; $display("FAIL rnd_head cyc %0d got %h %h %b exp %h %h %b", cyc, bus.mem_addr, bus.mem_wdata, bus.mem_byte_en, {mq[0].a, 2'b00}, mq[0].w, mq[0].be); end
      end
      tick();
    end
    set_idle();
    bus.mem_req_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) tick();
    bus.mem_req_ready = 1'b0;
    checks++; if (bus.sdu_empty !== 1'b1) begin errors++; $display("FAIL rnd_drained got %b exp 1", bus.sdu_empty); end
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 5; i++) begin
      drive_store($urandom, $urandom, 2'($urandom_range(0, 3)));
      tick();
    end
    bus.MemWrite_2DM  = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick();
    #2 RESET = 1'b0;
    #1;
    checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.mem_req_valid); end
    checks++; if (bus.sdu_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", bus.sdu_empty); end
    checks++; if (bus.sdu_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", bus.sdu_overflow); end
    mq.delete();
    m_ovf = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;
    checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_stale got %b exp 0", bus.mem_req_valid); end
    drive_store(32'h0000_5001, 32'h0000_BEEF, 2'd2);
    tick();
    bus.MemWrite_2DM = 1'b0;
    checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_byte_en} !== {32'h0000_5000, 32'h00BE_EF00, 4'b0110})
      begin errors++; $display("FAIL rst_first got %h %h %b exp 00005000 00beef00 0110", bus.mem_addr, bus.mem_wdata, bus.mem_byte_en); end
    tick();
    checks++; if (bus.sdu_empty !== 1'b1) begin errors++; $display("FAIL rst_single got %b exp 1", bus.sdu_empty); end
  endtask

  initial begin
    m_ovf = 1'b0;
    test_reset();
    test_byte_store();
    test_tri_overflow_lanes();
    test_forward();
    test_full_overflow();
    test_back_to_back();
    test_random();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
